// File: rtl/dut_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dut_bus_pkg
// Description : Shared types and default widths for the DUT bus master:
//               FSM state encoding, response entry layout, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package dut_bus_pkg;

    localparam int C_DEF_ADDR_W = 3;
    localparam int C_DEF_DATA_W = 1;

    // One command in flight: idle, driving a write, or driving a read
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    // Response FIFO entry at the default widths; packs as {addr, data, is_write}
    typedef struct packed {
        logic [C_DEF_ADDR_W-1:0] addr;
        logic [C_DEF_DATA_W-1:0] data;
        logic                    is_write;
    } rsp_entry_t;

endpackage : dut_bus_pkg
`default_nettype wire

// File: rtl/bus_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bus_rsp_fifo
// Description : Synchronous FIFO with registered storage and a combinational
//               head. Push while full and pop while empty are ignored.
//               DEPTH must be a power of two so pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rsp_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage write; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking; push+pop together keeps the count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : bus_rsp_fifo
`default_nettype wire

// File: rtl/dut_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : dut_bus_master
// Description : Issues one command at a time from a valid/ready command
//               channel onto the DUT write or read port, strobing only while
//               the matching ready is high, and queues read results in a
//               response FIFO.
//               Optional macro WRITE_ACK_EN: writes also push an ack entry
//               and are then held off while the response FIFO is full.
// Revision    : 1.0 - initial release
// ============================================================================
module dut_bus_master
    import dut_bus_pkg::*;
#(
    parameter int ADDR_W    = C_DEF_ADDR_W,
    parameter int DATA_W    = C_DEF_DATA_W,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_is_write,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              write_en,
    input  logic              write_ready,
    output logic [ADDR_W-1:0] read_addr,
    output logic              read_en,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_ready,
    output logic              busy
);

    localparam int c_ENTRY_W = ADDR_W + DATA_W + 1;
    localparam int c_CNT_W   = $clog2(RSP_DEPTH) + 1;

`ifdef WRITE_ACK_EN
    localparam logic c_ACK_EN = 1'b1;
`else
    localparam logic c_ACK_EN = 1'b0;
`endif

    state_t              r_state;
    logic [ADDR_W-1:0]   r_write_addr;
    logic [DATA_W-1:0]   r_write_data;
    logic [ADDR_W-1:0]   r_read_addr;

    logic                w_rsp_full;
    logic                w_rsp_empty;
    logic [c_CNT_W-1:0]  w_rsp_count;
    logic [c_ENTRY_W-1:0] w_rsp_head;
    logic                w_push;
    logic [c_ENTRY_W-1:0] w_push_data;
    logic                w_pop;

    assign cmd_ready  = (r_state == IDLE) && !reset;
    assign busy       = (r_state != IDLE);
    assign write_addr = r_write_addr;
    assign write_data = r_write_data;
    assign read_addr  = r_read_addr;

    // Strobes are gated by reset so an abandoned command never reaches the DUT
    assign write_en = (r_state == WR) && write_ready && !reset
                      && (!c_ACK_EN || !w_rsp_full);
    assign read_en  = (r_state == RD) && read_ready && !reset && !w_rsp_full;

    assign w_push      = read_en || (c_ACK_EN && write_en);
    assign w_push_data = read_en ? {r_read_addr, read_data, 1'b0}
                                 : {r_write_addr, r_write_data, 1'b1};
    assign w_pop       = rsp_valid && rsp_ready;

    // Head fields read as zero while the queue is empty
    assign rsp_valid    = (w_rsp_count != '0);
    assign rsp_addr     = w_rsp_empty ? '0 : w_rsp_head[c_ENTRY_W-1 -: ADDR_W];
    assign rsp_data     = w_rsp_empty ? '0 : w_rsp_head[DATA_W:1];
    assign rsp_is_write = !w_rsp_empty && w_rsp_head[0] && c_ACK_EN;

    // Command FSM: capture on acceptance, return to IDLE when the strobe fires
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_read_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_write) begin
                            r_write_addr <= cmd_addr;
                            r_write_data <= cmd_wdata;
                            r_state      <= WR;
                        end else begin
                            r_read_addr  <= cmd_addr;
                            r_state      <= RD;
                        end
                    end
                end
                WR: begin
                    if (write_en) begin
                        r_state <= IDLE;
                    end
                end
                RD: begin
                    if (read_en) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    bus_rsp_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_rsp_head),
        .o_full      (w_rsp_full),
        .o_empty     (w_rsp_empty),
        .o_count     (w_rsp_count)
    );

endmodule : dut_bus_master
`default_nettype wire

// File: tb/tb_dut_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_dut_bus_master
// Description : Directed self-checking bench for dut_bus_master at default
//               parameters (ADDR_W=3, DATA_W=1, RSP_DEPTH=4). The write-ack
//               section follows the WRITE_ACK_EN macro of the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dut_bus_master;
    import dut_bus_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [2:0] cmd_addr;
    logic [0:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [0:0] rsp_data;
    logic [2:0] rsp_addr;
    logic       rsp_is_write;
    logic [2:0] write_addr;
    logic [0:0] write_data;
    logic       write_en;
    logic       write_ready;
    logic [2:0] read_addr;
    logic       read_en;
    logic [0:0] read_data;
    logic       read_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    rsp_entry_t exp_q [5];

    dut_bus_master dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_addr     (rsp_addr),
        .rsp_is_write (rsp_is_write),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_en     (write_en),
        .write_ready  (write_ready),
        .read_addr    (read_addr),
        .read_en      (read_en),
        .read_data    (read_data),
        .read_ready   (read_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [2:0] addr, input logic [0:0] wdata);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
    endtask

    initial begin
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        rsp_ready   = 1'b0;
        write_ready = 1'b0;
        read_ready  = 1'b0;
        read_data   = '0;

        exp_q[0] = '{addr: 3'd1, data: 1'b1, is_write: 1'b0};
        exp_q[1] = '{addr: 3'd2, data: 1'b0, is_write: 1'b0};
        exp_q[2] = '{addr: 3'd5, data: 1'b1, is_write: 1'b0};
        exp_q[3] = '{addr: 3'd6, data: 1'b0, is_write: 1'b0};
        exp_q[4] = '{addr: 3'd7, data: 1'b1, is_write: 1'b0};

        // Reset state
        next(); next();
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_write_en", 32'(write_en), 0);
        chk("rst_read_en", 32'(read_en), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_write_addr", 32'(write_addr), 0);
        chk("rst_read_addr", 32'(read_addr), 0);
        chk("rst_rsp_fields", 32'({rsp_addr, rsp_data, rsp_is_write}), 0);

        // Write addr 4 data 1, DUT ready
        next();
        reset = 1'b0;
        write_ready = 1'b1;
        issue(1'b1, 3'd4, 1'b1);
        #1;
        chk("wr_cmd_ready_n", 32'(cmd_ready), 1);
        next();
        cmd_valid = 1'b0;
        #1;
        chk("wr_write_en_n1", 32'(write_en), 1);
        chk("wr_write_addr", 32'(write_addr), 4);
        chk("wr_write_data", 32'(write_data), 1);
        chk("wr_busy_n1", 32'(busy), 1);
        chk("wr_cmd_ready_n1", 32'(cmd_ready), 0);
        next();
        #1;
        chk("wr_write_en_n2", 32'(write_en), 0);
        chk("wr_cmd_ready_n2", 32'(cmd_ready), 1);
        chk("wr_no_rsp", 32'(rsp_valid), 0);

        // Write stalled by write_ready low for 5 cycles
        write_ready = 1'b0;
        issue(1'b1, 3'd2, 1'b0);
        next();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_write_en", 32'(write_en), 0);
            chk("stall_busy", 32'(busy), 1);
            chk("stall_cmd_ready", 32'(cmd_ready), 0);
            next();
        end
        write_ready = 1'b1;
        #1;
        chk("stall_release_en", 32'(write_en), 1);
        chk("stall_release_addr", 32'(write_addr), 2);
        next();
        #1;
        chk("stall_after_en", 32'(write_en), 0);
        chk("stall_after_ready", 32'(cmd_ready), 1);

        // Single read addr 3 data 1
        read_ready = 1'b1;
        read_data  = 1'b1;
        issue(1'b0, 3'd3, 1'b0);
        next();
        cmd_valid = 1'b0;
        #1;
        chk("rd_read_en", 32'(read_en), 1);
        chk("rd_read_addr", 32'(read_addr), 3);
        chk("rd_write_en_quiet", 32'(write_en), 0);
        chk("rd_rsp_not_yet", 32'(rsp_valid), 0);
        next();
        #1;
        chk("rd_read_en_off", 32'(read_en), 0);
        chk("rd_rsp_valid", 32'(rsp_valid), 1);
        chk("rd_rsp_addr", 32'(rsp_addr), 3);
        chk("rd_rsp_data", 32'(rsp_data), 1);
        chk("rd_rsp_is_write", 32'(rsp_is_write), 0);
        rsp_ready = 1'b1;
        next();
        rsp_ready = 1'b0;
        #1;
        chk("rd_popped", 32'(rsp_valid), 0);
        chk("rd_empty_data", 32'(rsp_data), 0);

        // Five reads into a 4-deep FIFO with no consumer
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, exp_q[i].addr, 1'b0);
            next();
            cmd_valid = 1'b0;
            read_data = exp_q[i].data;
            #1;
            chk("fill_read_en", 32'(read_en), 1);
            next();
        end
        issue(1'b0, exp_q[4].addr, 1'b0);
        next();
        cmd_valid = 1'b0;
        read_data = exp_q[4].data;
        #1;
        chk("full_read_blocked", 32'(read_en), 0);
        chk("full_busy", 32'(busy), 1);
        chk("full_head_addr", 32'(rsp_addr), 32'(exp_q[0].addr));
        next();
        #1;
        chk("full_still_blocked", 32'(read_en), 0);
        rsp_ready = 1'b1;
        #1;
        chk("full_pop_cycle_blocked", 32'(read_en), 0);
        next();
        rsp_ready = 1'b0;
        #1;
        chk("full_fifth_fires", 32'(read_en), 1);
        chk("full_head_after_pop", 32'(rsp_addr), 32'(exp_q[1].addr));
        next();
        #1;
        chk("full_fifth_done", 32'(read_en), 0);
        chk("full_cmd_ready", 32'(cmd_ready), 1);
        rsp_ready = 1'b1;
        for (int j = 1; j < 5; j++) begin
            #1;
            chk("drain_valid", 32'(rsp_valid), 1);
            chk("drain_addr", 32'(rsp_addr), 32'(exp_q[j].addr));
            chk("drain_data", 32'(rsp_data), 32'(exp_q[j].data));
            next();
        end
        rsp_ready = 1'b0;
        #1;
        chk("drain_empty", 32'(rsp_valid), 0);

        // Leave one response queued, then reset during a stalled read
        read_data = 1'b1;
        issue(1'b0, 3'd4, 1'b0);
        next();
        cmd_valid = 1'b0;
        next();
        #1;
        chk("pre_rst_rsp_valid", 32'(rsp_valid), 1);
        read_ready = 1'b0;
        issue(1'b0, 3'd6, 1'b0);
        next();
        cmd_valid = 1'b0;
        #1;
        chk("rdstall_busy", 32'(busy), 1);
        chk("rdstall_read_en", 32'(read_en), 0);
        chk("rdstall_read_addr", 32'(read_addr), 6);
        next();
        reset      = 1'b1;
        read_ready = 1'b1;
        #1;
        chk("rst_in_rd_read_en", 32'(read_en), 0);
        chk("rst_in_rd_cmd_ready", 32'(cmd_ready), 0);
        next();
        reset = 1'b0;
        #1;
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("post_rst_read_en", 32'(read_en), 0);
        chk("post_rst_read_addr", 32'(read_addr), 0);

        // Write addr 5 data 0: ack entry only when the macro is defined
        write_ready = 1'b1;
        issue(1'b1, 3'd5, 1'b0);
        next();
        cmd_valid = 1'b0;
        #1;
        chk("ack_write_en", 32'(write_en), 1);
        next();
        #1;
`ifdef WRITE_ACK_EN
        chk("ack_rsp_valid", 32'(rsp_valid), 1);
        chk("ack_rsp_addr", 32'(rsp_addr), 5);
        chk("ack_rsp_data", 32'(rsp_data), 0);
        chk("ack_rsp_is_write", 32'(rsp_is_write), 1);
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 3'd1, 1'b0);
            next();
            cmd_valid = 1'b0;
            next();
        end
        issue(1'b1, 3'd7, 1'b1);
        next();
        cmd_valid = 1'b0;
        #1;
        chk("ack_full_blocks_write", 32'(write_en), 0);
        chk("ack_full_busy", 32'(busy), 1);
`else
        chk("noack_rsp_valid", 32'(rsp_valid), 0);
        chk("noack_rsp_is_write", 32'(rsp_is_write), 0);
        chk("noack_cmd_ready", 32'(cmd_ready), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dut_bus_master
`default_nettype wire
